// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, transmitter state encoding and a parameter sanity check.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic bit uart_params_ok(input int data_bits, input int parity,
                                        input int stop_bits, input int baud_inc,
                                        input int baud_mod, input int fifo_depth);
    return (data_bits >= 5) && (data_bits <= 9)
        && (parity >= PAR_NONE) && (parity <= PAR_EVEN)
        && ((stop_bits == 1) || (stop_bits == 2))
        && (baud_inc >= 1) && (baud_inc <= baud_mod)
        && (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; shared by the UART transmitter and receiver.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign o_full    = (count == (AW+1)'(DEPTH));
  assign o_empty   = (count == '0);
  assign o_level   = count;
  assign o_rd_data = mem[rd_ptr];
  assign do_push   = i_push && !o_full;
  assign do_pop    = i_pop && !o_empty;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter with a fractional baud clock-enable and
// configurable data bits, parity and stop bits; frames go out back-to-back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_INC   = 9,
  parameter int BAUD_MOD   = 1250,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  input  logic [DATA_BITS-1:0]          i_data,
  output logic                          o_ready,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_uart_tx
);

  localparam int ACC_W = $clog2(BAUD_MOD + BAUD_INC);
  localparam int CNT_W = 4;

  if (!uart_params_ok(DATA_BITS, PARITY, STOP_BITS, BAUD_INC, BAUD_MOD, FIFO_DEPTH)) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

  logic [ACC_W-1:0]     acc;
  logic [ACC_W:0]       acc_sum;
  logic                 tick;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_data;
  tx_state_t            state;
  logic [DATA_BITS-1:0] shifter;
  logic [CNT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 parity_bit;
  logic                 last_stop;

  assign acc_sum = {1'b0, acc} + (ACC_W+1)'(BAUD_INC);
  assign tick    = (acc_sum >= (ACC_W+1)'(BAUD_MOD));

  // Free-running fractional accumulator; never re-phased by frame activity.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) acc <= '0;
    else          acc <= tick ? ACC_W'(acc_sum - (ACC_W+1)'(BAUD_MOD)) : acc_sum[ACC_W-1:0];
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (i_valid && !fifo_full),
    .i_pop     (fifo_pop),
    .i_wr_data (i_data),
    .o_rd_data (fifo_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_level   (o_level)
  );

  assign o_ready   = !fifo_full;
  assign o_busy    = (state != ST_IDLE) || !fifo_empty;
  assign last_stop = (STOP_BITS == 1) || stop_idx;
  assign fifo_pop  = tick && !fifo_empty
                  && ((state == ST_IDLE) || ((state == ST_STOP) && last_stop));

  // A pop always starts a new frame, whether from IDLE or straight out of the last stop bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      shifter    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      parity_bit <= 1'b0;
      o_uart_tx  <= 1'b1;
    end else if (tick) begin
      if (fifo_pop) begin
        state      <= ST_START;
        shifter    <= fifo_data;
        parity_bit <= (^fifo_data) ^ (PARITY == PAR_ODD);
        o_uart_tx  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: o_uart_tx <= 1'b1;
          ST_START: begin
            o_uart_tx <= shifter[0];
            shifter   <= shifter >> 1;
            bit_idx   <= '0;
            state     <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_idx == CNT_W'(DATA_BITS - 1)) begin
              if (PARITY != PAR_NONE) begin
                o_uart_tx <= parity_bit;
                state     <= ST_PARITY;
              end else begin
                o_uart_tx <= 1'b1;
                stop_idx  <= 1'b0;
                state     <= ST_STOP;
              end
            end else begin
              o_uart_tx <= shifter[0];
              shifter   <= shifter >> 1;
              bit_idx   <= bit_idx + CNT_W'(1);
            end
          end
          ST_PARITY: begin
            o_uart_tx <= 1'b1;
            stop_idx  <= 1'b0;
            state     <= ST_STOP;
          end
          ST_STOP: begin
            if (last_stop) state    <= ST_IDLE;
            else           stop_idx <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: 8N1, 7E2 and 7O2 at one symbol per cycle,
// plus the default 9/1250 baud rate for tick spacing.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a_valid, a_ready, a_busy, a_tx;
  logic [7:0] a_data;
  logic [2:0] a_level;
  logic       e_valid, e_ready, e_busy, e_tx;
  logic [6:0] e_data;
  logic [2:0] e_level;
  logic       o_valid, o_ready, o_busy, o_tx;
  logic [6:0] o_data;
  logic [2:0] o_level;
  logic       b_valid, b_ready, b_busy, b_tx;
  logic [7:0] b_data;
  logic [2:0] b_level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.BAUD_INC(1), .BAUD_MOD(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .i_data(a_data),
    .o_ready(a_ready), .o_busy(a_busy), .o_level(a_level), .o_uart_tx(a_tx));

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .BAUD_INC(1), .BAUD_MOD(1)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(e_valid), .i_data(e_data),
    .o_ready(e_ready), .o_busy(e_busy), .o_level(e_level), .o_uart_tx(e_tx));

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .BAUD_INC(1), .BAUD_MOD(1)) dut_o (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(o_valid), .i_data(o_data),
    .o_ready(o_ready), .o_busy(o_busy), .o_level(o_level), .o_uart_tx(o_tx));

  uart_tx_fifo dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .i_data(b_data),
    .o_ready(b_ready), .o_busy(b_busy), .o_level(b_level), .o_uart_tx(b_tx));

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return a_tx;
      1:       return e_tx;
      2:       return o_tx;
      default: return b_tx;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return a_busy;
      1:       return e_busy;
      2:       return o_busy;
      default: return b_busy;
    endcase
  endfunction

  // Reference frame builder: start, data LSB first, optional parity, stop bits.
  function automatic void push_frame(input logic [8:0] d, input int db, input int par, input int sb);
    bit p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      exp_q.push_back(d[i]);
      p ^= d[i];
    end
    if (par != 0) exp_q.push_back((par == 1) ? ~p : p);
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
  endfunction

  task automatic write_word(input int sel, input logic [8:0] d);
    @(negedge clk);
    case (sel)
      0:       begin a_valid = 1'b1; a_data = d[7:0]; end
      1:       begin e_valid = 1'b1; e_data = d[6:0]; end
      2:       begin o_valid = 1'b1; o_data = d[6:0]; end
      default: begin b_valid = 1'b1; b_data = d[7:0]; end
    endcase
    @(posedge clk);
    #1;
    a_valid = 1'b0; e_valid = 1'b0; o_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic wait_tx_low(input int sel, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_of(sel) == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; e_valid = 1'b0; o_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; e_data = '0; o_data = '0; b_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: got %b, expected 1", a_tx); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b, expected 1", a_ready); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", a_busy); end
    checks++; if (a_level !== 3'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d, expected 0", a_level); end
    checks++; if ({e_tx, o_tx, b_tx} !== 3'b111) begin failures++; $display("[TB] FAIL reset_tx_others: got %b, expected 111", {e_tx, o_tx, b_tx}); end
    checks++; if ({e_ready, o_ready, b_ready} !== 3'b111) begin failures++; $display("[TB] FAIL reset_ready_others: got %b, expected 111", {e_ready, o_ready, b_ready}); end
    checks++; if ({e_level, o_level, b_level} !== 9'd0) begin failures++; $display("[TB] FAIL reset_level_others: got %h, expected 0", {e_level, o_level, b_level}); end
    checks++; if ({e_busy, o_busy, b_busy} !== 3'b000) begin failures++; $display("[TB] FAIL reset_busy_others: got %b, expected 000", {e_busy, o_busy, b_busy}); end
  endtask

  task automatic test_frame_8n1();
    logic [9:0] lit;
    bit want;
    lit = 10'b1010010000;
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(lit[i]);
    write_word(0, 9'h048);
    @(negedge clk);
    checks++; if (a_tx !== 1'b1) begin failures++; $display("[TB] FAIL 8n1_latency_idle: got %b, expected 1", a_tx); end
    checks++; if (a_busy !== 1'b1) begin failures++; $display("[TB] FAIL 8n1_busy_rise: got %b, expected 1", a_busy); end
    checks++; if (a_level !== 3'd1) begin failures++; $display("[TB] FAIL 8n1_level: got %0d, expected 1", a_level); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (a_tx !== want) begin failures++; $display("[TB] FAIL 8n1_bit%0d: got %b, expected %b", i, a_tx, want); end
    end
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin failures++; $display("[TB] FAIL 8n1_busy_fall: got %b, expected 0", a_busy); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_tx !== 1'b1) begin failures++; $display("[TB] FAIL 8n1_idle%0d: got %b, expected 1", i, a_tx); end
      @(negedge clk);
    end
  endtask

  task automatic test_parity();
    logic [10:0] lit_even;
    logic [10:0] lit_odd;
    logic [8:0]  d;
    int          sel;
    bit          want;
    lit_even = 11'b11011001010;
    lit_odd  = 11'b11111001010;
    for (int k = 0; k < 4; k++) begin
      sel = (k % 2 == 0) ? 1 : 2;
      d   = (k < 2) ? 9'h065 : 9'h07F;
      exp_q.delete();
      if (k == 0)      for (int i = 0; i < 11; i++) exp_q.push_back(lit_even[i]);
      else if (k == 1) for (int i = 0; i < 11; i++) exp_q.push_back(lit_odd[i]);
      else             push_frame(d, 7, (sel == 1) ? 2 : 1, 2);
      write_word(sel, d);
      @(negedge clk);
      checks++;
      if (tx_of(sel) !== 1'b1) begin failures++; $display("[TB] FAIL parity%0d_idle: got %b, expected 1", k, tx_of(sel)); end
      for (int i = 0; i < 11; i++) begin
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (tx_of(sel) !== want) begin failures++; $display("[TB] FAIL parity%0d_bit%0d: got %b, expected %b", k, i, tx_of(sel), want); end
      end
      @(negedge clk);
      checks++;
      if (busy_of(sel) !== 1'b0) begin failures++; $display("[TB] FAIL parity%0d_busy_fall: got %b, expected 0", k, busy_of(sel)); end
    end
  endtask

  // A filler frame keeps the FSM busy so five writes can fill the FIFO.
  task automatic test_fifo_full();
    bit seen;
    bit want;
    exp_q.delete();
    push_frame(9'h000, 8, 0, 1);
    write_word(0, 9'h000);
    wait_tx_low(0, 20, seen);
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL fifo_start: line stayed %b, expected a 0 start bit", a_tx); return; end
    want = exp_q.pop_front();
    fork
      begin
        int guard;
        for (int i = 1; i <= 5; i++) begin
          a_valid = 1'b1;
          a_data  = 8'(i);
          guard   = 0;
          while (!a_ready && guard < 30) begin
            @(negedge clk);
            guard++;
          end
          if (i == 5) begin
            checks++;
            if (guard != 6) begin failures++; $display("[TB] FAIL fifo_hold_cycles: got %0d, expected 6", guard); end
          end
          push_frame(9'(i), 8, 0, 1);
          @(posedge clk);
          #1;
          if (i == 5) a_valid = 1'b0;
          @(negedge clk);
          if (i == 4) begin
            checks++; if (a_level !== 3'd4) begin failures++; $display("[TB] FAIL fifo_level_full: got %0d, expected 4", a_level); end
            checks++; if (a_ready !== 1'b0) begin failures++; $display("[TB] FAIL fifo_ready_full: got %b, expected 0", a_ready); end
          end
        end
      end
      begin
        for (int k = 1; k < 60; k++) begin
          @(negedge clk);
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("[TB] FAIL fifo_bit%0d: got %b, expected nothing queued", k, a_tx);
          end else begin
            want = exp_q.pop_front();
            if (a_tx !== want) begin failures++; $display("[TB] FAIL fifo_bit%0d: got %b, expected %b", k, a_tx, want); end
          end
        end
      end
    join
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin failures++; $display("[TB] FAIL fifo_busy_fall: got %b, expected 0", a_busy); end
    checks++; if (a_level !== 3'd0) begin failures++; $display("[TB] FAIL fifo_level_end: got %0d, expected 0", a_level); end
  endtask

  task automatic test_push_pop_same_cycle();
    bit seen;
    bit want;
    exp_q.delete();
    push_frame(9'h000, 8, 0, 1);
    write_word(0, 9'h000);
    wait_tx_low(0, 20, seen);
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL pp_start: line stayed %b, expected a 0 start bit", a_tx); return; end
    want = exp_q.pop_front();
    fork
      begin
        a_valid = 1'b1; a_data = 8'h3C; push_frame(9'h03C, 8, 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        a_data = 8'hA5; push_frame(9'h0A5, 8, 0, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (a_level !== 3'd2) begin failures++; $display("[TB] FAIL pp_level_before: got %0d, expected 2", a_level); end
        a_valid = 1'b1; a_data = 8'h81; push_frame(9'h081, 8, 0, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_level !== 3'd2) begin failures++; $display("[TB] FAIL pp_level_after: got %0d, expected 2", a_level); end
      end
      begin
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("[TB] FAIL pp_bit%0d: got %b, expected nothing queued", k, a_tx);
          end else begin
            want = exp_q.pop_front();
            if (a_tx !== want) begin failures++; $display("[TB] FAIL pp_bit%0d: got %b, expected %b", k, a_tx, want); end
          end
        end
      end
    join
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin failures++; $display("[TB] FAIL pp_busy_fall: got %b, expected 0", a_busy); end
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    bit want;
    exp_q.delete();
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    a_valid = 1'b0;
    wait_tx_low(0, 20, seen);
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL rst_start: line stayed %b, expected a 0 start bit", a_tx); return; end
    repeat (3) @(negedge clk);
    checks++; if (a_tx !== 1'b0) begin failures++; $display("[TB] FAIL rst_pre_bit: got %b, expected 0", a_tx); end
    checks++; if (a_level !== 3'd3) begin failures++; $display("[TB] FAIL rst_pre_level: got %0d, expected 3", a_level); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_tx !== 1'b1) begin failures++; $display("[TB] FAIL rst_async_tx: got %b, expected 1", a_tx); end
    checks++; if (a_level !== 3'd0) begin failures++; $display("[TB] FAIL rst_level: got %0d, expected 0", a_level); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b, expected 0", a_busy); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready: got %b, expected 1", a_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_frame(9'h0C3, 8, 0, 1);
    write_word(0, 9'h0C3);
    @(negedge clk);
    checks++; if (a_tx !== 1'b1) begin failures++; $display("[TB] FAIL rst_after_idle: got %b, expected 1", a_tx); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (a_tx !== want) begin failures++; $display("[TB] FAIL rst_after_bit%0d: got %b, expected %b", i, a_tx, want); end
    end
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_after_busy: got %b, expected 0", a_busy); end
  endtask

  // 0x55 toggles the line every symbol, so each edge marks one baud tick.
  task automatic test_baud();
    bit   seen;
    logic prev;
    int   t0;
    int   t_last;
    int   t_now;
    int   guard;
    write_word(3, 9'h055);
    wait_tx_low(3, 300, seen);
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL baud_start: line stayed %b, expected a 0 start bit", b_tx); return; end
    t0     = cyc;
    t_last = t0;
    prev   = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      guard = 0;
      while (b_tx === prev && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (guard >= 300) begin failures++; $display("[TB] FAIL baud_edge%0d: line stuck at %b, expected a toggle", k, b_tx); return; end
      t_now = cyc;
      if ((t_now - t_last) != 138 && (t_now - t_last) != 139) begin
        failures++; $display("[TB] FAIL baud_interval%0d: got %0d cycles, expected 138 or 139", k, t_now - t_last);
      end
      t_last = t_now;
      prev   = b_tx;
    end
    checks++;
    if ((t_last - t0) != 1250) begin failures++; $display("[TB] FAIL baud_nine_ticks: got %0d cycles, expected 1250", t_last - t0); end
    guard = 0;
    while (b_busy !== 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if ((cyc - t0) != 1388 && (cyc - t0) != 1389) begin
      failures++; $display("[TB] FAIL baud_frame_len: got %0d cycles, expected 1388 or 1389", cyc - t0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_frame_8n1();
    test_parity();
    test_fifo_full();
    test_push_pop_same_cycle();
    test_reset_mid_frame();
    test_baud();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
